shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Sequencer for the serial shift-register datapath.
- Accepts a parallel word over a valid/ready handshake and drives it bit-serially into the shift register's serial input.
- Flushes the register and rebuilds the word from the register's serial output, then presents it on a valid/ready result port.
- Sits between a parallel producer/consumer and one shift_register instance, which it owns exclusively.

Parameters:
- WIDTH, 8, bits per word transferred.
- DEPTH, 4, shift-register stage count; cycles from a bit on sr_in to that bit on sr_out, must be >= 1.
- CNT_W, 8, cycle-counter width; must hold WIDTH+DEPTH-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- load_valid  input  1  producer has a word
- load_ready  output  1  controller can accept a word
- load_data  input  WIDTH  word to serialize
- sr_in  output  1  serial bit to the shift register input
- sr_out  input  1  serial bit from the shift register output
- res_valid  output  1  reconstructed word available
- res_ready  input  1  consumer accepts the word
- res_data  output  WIDTH  reconstructed word
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high, sampled on the rising edge.
- Reset values: state=IDLE, load_ready=1, sr_in=0, res_valid=0, res_data=0, busy=0, counter=0.
- Reset asserted mid-operation aborts the transfer at the next edge. The partial word is discarded and no res_valid pulse is produced.
- Shift-register contents are not cleared by reset; the controller ignores sr_out outside RUN.
- All outputs are registered.
- States:
  - IDLE: load_ready=1. On load_valid&load_ready, latch load_data into tx_reg, clear rx_reg and counter, go to RUN.
  - RUN: lasts exactly WIDTH+DEPTH cycles, counted by counter k = 0..WIDTH+DEPTH-1. load_ready=0.
  - DONE: res_valid=1 and res_data=rx_reg, both held stable until res_ready. On res_valid&res_ready go to IDLE.
- RUN, driving sr_in:
  - sr_in = tx_reg[k] for k < WIDTH, LSB first.
  - sr_in = 0 for k >= WIDTH (flush).
- RUN, capture: for k >= DEPTH, rx_reg[k-DEPTH] <= sr_out at the edge ending cycle k.
- RUN, exit: at the edge ending k = WIDTH+DEPTH-1, go to DONE.
- Latency: first RUN cycle is the cycle after the accepting edge. res_valid rises WIDTH+DEPTH+1 cycles after the accept edge.
- load_valid during RUN or DONE is ignored: load_ready=0 and the producer holds its data.
- res_ready while res_valid=0 is ignored.
- No overlap between words. The next accept is possible the cycle after the DONE handshake, since load_ready returns to 1 in IDLE.
- Counter compare uses CNT_W-bit unsigned arithmetic; no wrap occurs within a transfer.

Optional Feature:
- Macro: SHIFT_SEQ_CHECK_EN.
- Defined:
  - Adds output port mismatch (1 bit, reset 0).
  - On entry to DONE, mismatch <= (rx_reg != tx_reg), valid while res_valid=1 and cleared on the DONE handshake.
  - This is a loopback integrity check of the shift register.
- Undefined: port absent, no comparator, tx_reg need not be retained after RUN.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> load_ready=1, res_valid=0, sr_in=0, busy=0, res_data=0x00.
- Single word, WIDTH=8, DEPTH=4, load_data=0xA5:
  - sr_in sequence 1,0,1,0,0,1,0,1 then 0,0,0,0.
  - res_valid rises 13 cycles after the accept edge with res_data=0xA5.
  - With SHIFT_SEQ_CHECK_EN, mismatch=0.
- Back-pressure: res_ready=0 for 5 cycles after res_valid -> res_data stays 0xA5 and load_ready stays 0. Second word 0x3C is accepted only after the handshake and returns 0x3C.
- Busy rejection: load_valid held with 0xFF during RUN -> not accepted until IDLE; the first result is unchanged.
- Reset mid-RUN at k=6 -> IDLE next cycle with no res_valid. A following word 0x81 returns 0x81 correctly, despite stale bits in the register.
- With SHIFT_SEQ_CHECK_EN and the shift-register model's sr_out forced to 0, send 0x5A -> res_data=0x00, mismatch=1.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_ctrl
// Description : Serialises a parallel word into a shift register, flushes it,
//               and rebuilds the word from the register's serial output.
//               Optional loopback check enabled by SHIFT_SEQ_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sr_in,
    input  logic             sr_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
`ifdef SHIFT_SEQ_CHECK_EN
    output logic             mismatch,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST_K    = CNT_W'(WIDTH + DEPTH - 1);
    localparam logic [CNT_W-1:0] c_FIRST_CAP = CNT_W'(DEPTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_tx_sh;
    logic [WIDTH-1:0] r_rx;
    logic [WIDTH-1:0] w_rx_nxt;
    logic             w_accept;
    logic             w_last;
    logic             w_cap;
    logic             w_res_hs;
`ifdef SHIFT_SEQ_CHECK_EN
    logic [WIDTH-1:0] r_tx_ref;
`endif

    assign w_accept = (r_state == S_IDLE) && load_valid && load_ready;
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_LAST_K);
    assign w_cap    = (r_state == S_RUN) && (r_cnt >= c_FIRST_CAP);
    assign w_res_hs = (r_state == S_DONE) && res_valid && res_ready;
    // Bits arrive LSB first, so shifting in at the MSB lands bit 0 at the bottom.
    assign w_rx_nxt = w_cap ? {sr_out, r_rx[WIDTH-1:1]} : r_rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)   w_state_nxt = S_DONE;
            S_DONE:  if (w_res_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_ready <= 1'b1;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            sr_in      <= 1'b0;
            r_cnt      <= '0;
            r_tx_sh    <= '0;
            r_rx       <= '0;
`ifdef SHIFT_SEQ_CHECK_EN
            mismatch   <= 1'b0;
            r_tx_ref   <= '0;
`endif
        end else begin
            // Status outputs are registered copies of the upcoming state.
            load_ready <= (w_state_nxt == S_IDLE);
            busy       <= (w_state_nxt != S_IDLE);
            res_valid  <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        sr_in   <= load_data[0];
                        r_tx_sh <= load_data >> 1;
                        r_rx    <= '0;
                        r_cnt   <= '0;
`ifdef SHIFT_SEQ_CHECK_EN
                        r_tx_ref <= load_data;
`endif
                    end
                end
                S_RUN: begin
                    // The shifter empties to zero after WIDTH bits, giving the flush.
                    r_cnt   <= r_cnt + 1'b1;
                    r_tx_sh <= r_tx_sh >> 1;
                    sr_in   <= w_last ? 1'b0 : r_tx_sh[0];
                    r_rx    <= w_rx_nxt;
                    if (w_last) begin
                        res_data <= w_rx_nxt;
`ifdef SHIFT_SEQ_CHECK_EN
                        mismatch <= (w_rx_nxt != r_tx_ref);
`endif
                    end
                end
                S_DONE: begin
`ifdef SHIFT_SEQ_CHECK_EN
                    if (w_res_hs) mismatch <= 1'b0;
`endif
                end
                default: begin
                    sr_in <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// Directed bench for shift_seq_ctrl with a DEPTH-stage shift register model.
module tb_shift_seq_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             sr_in;
    logic             sr_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;
`ifdef SHIFT_SEQ_CHECK_EN
    logic             mismatch;
`endif
    logic [DEPTH-1:0] sr_chain;
    logic             force_zero;
    int               checks   = 0;
    int               failures = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .sr_in      (sr_in),
        .sr_out     (sr_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
`ifdef SHIFT_SEQ_CHECK_EN
        .mismatch   (mismatch),
`endif
        .busy       (busy)
    );

    // Shift register model: a bit on sr_in appears on sr_out DEPTH cycles later.
    initial sr_chain = 4'b1011;
    always @(posedge clk) sr_chain <= {sr_chain[DEPTH-2:0], sr_in};
    assign sr_out = force_zero ? 1'b0 : sr_chain[DEPTH-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a word and return once it is accepted; inputs change on negedges.
    task automatic send(input logic [WIDTH-1:0] d);
        int n;
        load_valid = 1'b1;
        load_data  = d;
        n = 0;
        while (!load_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 40), 32'd1);
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until res_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        logic [11:0] exp_seq;
        int          lat;
        logic        saw_valid;

        force_zero = 1'b0;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        res_ready  = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            load_valid = 1'($urandom);
            load_data  = 8'($urandom);
            res_ready  = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_res_valid",  32'(res_valid),  32'd0);
        chk("rst_sr_in",      32'(sr_in),      32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_res_data",   32'(res_data),   32'h00);
        rst        = 1'b0;
        load_valid = 1'b0;
        res_ready  = 1'b0;
        @(negedge clk);

        // Single word 0xA5: serial pattern and latency
        exp_seq = 12'b0000_1010_0101;
        send(8'hA5);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("a5_sr_in_k%0d", k), 32'(sr_in), 32'(exp_seq[k]));
            chk($sformatf("a5_valid_low_k%0d", k), 32'(res_valid), 32'd0);
            chk($sformatf("a5_busy_k%0d", k), 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("a5_res_valid_cycle13", 32'(res_valid), 32'd1);
        chk("a5_res_data", 32'(res_data), 32'hA5);
`ifdef SHIFT_SEQ_CHECK_EN
        chk("a5_mismatch", 32'(mismatch), 32'd0);
`endif

        // Back-pressure with the next word already offered
        load_valid = 1'b1;
        load_data  = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_res_data", 32'(res_data), 32'hA5);
            chk("bp_load_ready", 32'(load_ready), 32'd0);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
        end
        handshake();
        chk("hs_res_valid", 32'(res_valid), 32'd0);
        chk("hs_load_ready", 32'(load_ready), 32'd1);
        chk("hs_busy", 32'(busy), 32'd0);
        send(8'h3C);
        wait_valid(lat);
        chk("3c_latency", 32'(lat), 32'd13);
        chk("3c_res_data", 32'(res_data), 32'h3C);
        handshake();

        // Busy rejection: 0xFF held during RUN must wait for IDLE
        send(8'h66);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        wait_valid(lat);
        chk("66_latency", 32'(lat), 32'd13);
        chk("66_res_data", 32'(res_data), 32'h66);
        @(negedge clk);
        chk("66_load_ready", 32'(load_ready), 32'd0);
        chk("66_res_data_hold", 32'(res_data), 32'h66);
        handshake();
        send(8'hFF);
        wait_valid(lat);
        chk("ff_latency", 32'(lat), 32'd13);
        chk("ff_res_data", 32'(res_data), 32'hFF);
        handshake();

        // Reset at RUN cycle k=6 aborts with no result
        send(8'hC3);
        for (int k = 0; k < 6; k++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_load_ready", 32'(load_ready), 32'd1);
        chk("abort_sr_in", 32'(sr_in), 32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            saw_valid = saw_valid | res_valid;
            @(negedge clk);
        end
        chk("abort_no_valid", 32'(saw_valid), 32'd0);
        send(8'h81);
        wait_valid(lat);
        chk("81_latency", 32'(lat), 32'd13);
        chk("81_res_data", 32'(res_data), 32'h81);
        handshake();

`ifdef SHIFT_SEQ_CHECK_EN
        // Broken loopback: sr_out stuck at 0
        force_zero = 1'b1;
        send(8'h5A);
        wait_valid(lat);
        chk("5a_latency", 32'(lat), 32'd13);
        chk("5a_res_data", 32'(res_data), 32'h00);
        chk("5a_mismatch", 32'(mismatch), 32'd1);
        handshake();
        chk("5a_mismatch_clr", 32'(mismatch), 32'd0);
        force_zero = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
